// File: rtl/sync_pol_norm.sv
// rtl/sync_pol_norm.sv - per-channel sync polarity detector and normaliser
// Polarity is chosen so the shorter phase of each sync ends up active-high.
module sync_pol_norm #(
  parameter int CHANNELS = 2,
  parameter int CW       = 16,
  parameter int HYST     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sync_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] pol,
  output logic [CHANNELS-1:0] locked
);

  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [3:0]    HYST4 = 4'(HYST);

  logic [CHANNELS-1:0] s1_q, s2_q;
  logic [CHANNELS-1:0] low_vld_q, low_vld_d, high_vld_q, high_vld_d;
  logic [CHANNELS-1:0] pol_q, pol_d, locked_q, locked_d;
  logic [CW-1:0]       cnt_q      [CHANNELS];
  logic [CW-1:0]       cnt_d      [CHANNELS];
  logic [CW-1:0]       low_len_q  [CHANNELS];
  logic [CW-1:0]       low_len_d  [CHANNELS];
  logic [CW-1:0]       high_len_q [CHANNELS];
  logic [CW-1:0]       high_len_d [CHANNELS];
  logic [3:0]          agree_q    [CHANNELS];
  logic [3:0]          agree_d    [CHANNELS];

  logic [CHANNELS-1:0] rise, fall, cand, tmo;
  logic [3:0]          agree_inc  [CHANNELS];

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      rise[i]      = s1_q[i] & ~s2_q[i];
      fall[i]      = ~s1_q[i] & s2_q[i];
      cand[i]      = cnt_q[i] > low_len_q[i];
      // An edge on the saturating cycle wins: the counter restarts instead.
      tmo[i]       = (cnt_q[i] == CMAX) & ~rise[i] & ~fall[i];
      agree_inc[i] = agree_q[i] + 4'd1;
    end
  end

  always_comb begin
    low_vld_d  = low_vld_q;
    high_vld_d = high_vld_q;
    pol_d      = pol_q;
    locked_d   = locked_q;
    cnt_d      = cnt_q;
    low_len_d  = low_len_q;
    high_len_d = high_len_q;
    agree_d    = agree_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rise[i] | fall[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CMAX) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      if (rise[i]) begin
        low_len_d[i] = cnt_q[i];
        low_vld_d[i] = 1'b1;
      end
      if (fall[i]) begin
        high_len_d[i] = cnt_q[i];
        high_vld_d[i] = 1'b1;
        if (low_vld_q[i]) begin
          if (cand[i] == pol_q[i]) begin
            agree_d[i]  = 4'd0;
            locked_d[i] = 1'b1;
          end else if (agree_inc[i] == HYST4) begin
            pol_d[i]    = cand[i];
            agree_d[i]  = 4'd0;
            locked_d[i] = 1'b1;
          end else begin
            agree_d[i]  = agree_inc[i];
          end
        end
      end
      if (tmo[i]) begin
        locked_d[i]   = 1'b0;
        low_vld_d[i]  = 1'b0;
        high_vld_d[i] = 1'b0;
        agree_d[i]    = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      low_vld_q  <= '0;
      high_vld_q <= '0;
      pol_q      <= '0;
      locked_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]      <= '0;
        low_len_q[i]  <= '0;
        high_len_q[i] <= '0;
        agree_q[i]    <= '0;
      end
    end else begin
      s1_q       <= sync_in;
      s2_q       <= s1_q;
      low_vld_q  <= low_vld_d;
      high_vld_q <= high_vld_d;
      pol_q      <= pol_d;
      locked_q   <= locked_d;
      cnt_q      <= cnt_d;
      low_len_q  <= low_len_d;
      high_len_q <= high_len_d;
      agree_q    <= agree_d;
    end
  end

  assign sync_out = sync_in ^ pol_q;
  assign pol      = pol_q;
  assign locked   = locked_q;

endmodule
